// File: rtl/rv_pkg.sv
// Shared RV32I decode package: format classes, ALU operation codes,
// write-back sources, memory access sizes and base opcode constants.
// Used by the decoder and by the execute stage.
package rv_pkg;

    typedef enum logic [2:0] {
        FT_NONE = 3'd0,
        FT_R    = 3'd1,
        FT_I    = 3'd2,
        FT_S    = 3'd3,
        FT_B    = 3'd4,
        FT_U    = 3'd5,
        FT_J    = 3'd6
    } fmt_t;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_EQ     = 5'd10,
        ALU_NE     = 5'd11,
        ALU_LT     = 5'd12,
        ALU_GE     = 5'd13,
        ALU_LTU    = 5'd14,
        ALU_GEU    = 5'd15,
        ALU_PASS_B = 5'd16,
        ALU_MUL    = 5'd17,
        ALU_MULH   = 5'd18,
        ALU_MULHSU = 5'd19,
        ALU_MULHU  = 5'd20,
        ALU_DIV    = 5'd21,
        ALU_DIVU   = 5'd22,
        ALU_REM    = 5'd23,
        ALU_REMU   = 5'd24
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PC4  = 2'd3
    } wb_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } mem_size_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Integer ALU map shared by OP and OP-IMM; alt selects SUB/SRA.
    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate generator: rebuilds the sign-extended
// immediate for the given format class; R and NONE produce zero.
module rv32i_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir,
    input  fmt_t            format,
    output logic [XLEN-1:0] imm
);

    // Select the bit layout that matches the format class.
    always_comb begin
        imm = '0;
        case (format)
            FT_I: imm = {{20{ir[31]}}, ir[31:20]};
            FT_S: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            FT_B: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            FT_U: imm = {ir[31:12], 12'b0};
            FT_J: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_instruction_decoder.sv
// Registered RV32I instruction decoder (1-cycle latency).
// Optional macro RV32M_EN adds decode of the M-extension OP encodings;
// without it those encodings decode to the all-zero bubble.
module rv32i_instruction_decoder
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     IR,
    output logic [4:0]      alu_instruction,
    output logic [XLEN-1:0] immediate_value,
    output logic [2:0]      instruction_format_type,
    output logic [1:0]      write_back_type,
    output logic [1:0]      read_status,
    output logic [1:0]      write_status,
    output logic            load_signed,
    output logic [4:0]      destination_register_number,
    output logic            pc_for_input_a,
    output logic            change_branch_instruction
);

    typedef struct packed {
        alu_op_t   alu;
        fmt_t      fmt;
        wb_t       wb;
        mem_size_t rsize;
        mem_size_t wsize;
        logic      lsigned;
        logic      pc_a;
        logic      branch;
    } ctrl_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    ctrl_t           dec;
    logic [XLEN-1:0] imm_next;
    logic [4:0]      rd_next;
    ctrl_t           ctrl_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rd_q;

    assign opcode = IR[6:0];
    assign funct3 = IR[14:12];
    assign funct7 = IR[31:25];

    // Opcode/funct decode; anything not matched stays the all-zero bubble.
    always_comb begin
        dec = '0;
        case (opcode)
            OPC_OP: begin
`ifdef RV32M_EN
                if (funct7 == 7'b0000001) begin
                    dec.fmt = FT_R;
                    dec.wb  = WB_ALU;
                    dec.alu = alu_op_t'(5'(ALU_MUL) + {2'b00, funct3});
                end else
`endif
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec.fmt = FT_R;
                    dec.wb  = WB_ALU;
                    dec.alu = alu_from_funct3(funct3, funct7[5]);
                end
            end
            OPC_OP_IMM: begin
                dec.fmt = FT_I;
                dec.wb  = WB_ALU;
                dec.alu = alu_from_funct3(funct3, funct3 == 3'b101 && funct7[5]);
            end
            OPC_LOAD: begin
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
                    dec.fmt     = FT_I;
                    dec.wb      = WB_MEM;
                    dec.alu     = ALU_ADD;
                    dec.lsigned = ~funct3[2];
                    dec.rsize   = mem_size_t'({1'b0, funct3[1:0]} + 3'd1);
                end
            end
            OPC_STORE: begin
                if (funct3[2] == 1'b0 && funct3[1:0] != 2'b11) begin
                    dec.fmt   = FT_S;
                    dec.alu   = ALU_ADD;
                    dec.wsize = mem_size_t'(funct3[1:0] + 2'd1);
                end
            end
            OPC_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    dec.fmt    = FT_B;
                    dec.branch = 1'b1;
                    case (funct3)
                        3'b000:  dec.alu = ALU_EQ;
                        3'b001:  dec.alu = ALU_NE;
                        3'b100:  dec.alu = ALU_LT;
                        3'b101:  dec.alu = ALU_GE;
                        3'b110:  dec.alu = ALU_LTU;
                        default: dec.alu = ALU_GEU;
                    endcase
                end
            end
            OPC_JAL: begin
                dec.fmt    = FT_J;
                dec.wb     = WB_PC4;
                dec.pc_a   = 1'b1;
                dec.branch = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    dec.fmt    = FT_I;
                    dec.wb     = WB_PC4;
                    dec.branch = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.fmt = FT_U;
                dec.wb  = WB_ALU;
                dec.alu = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                dec.fmt  = FT_U;
                dec.wb   = WB_ALU;
                dec.pc_a = 1'b1;
            end
            default: dec = '0;
        endcase
    end

    rv32i_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .ir     (IR),
        .format (dec.fmt),
        .imm    (imm_next)
    );

    // rd is only meaningful for formats that write a register.
    always_comb begin
        rd_next = 5'd0;
        if (dec.fmt == FT_R || dec.fmt == FT_I || dec.fmt == FT_U || dec.fmt == FT_J)
            rd_next = IR[11:7];
    end

    // Pipeline register; reset forces the all-zero bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
            imm_q  <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= dec;
            imm_q  <= imm_next;
            rd_q   <= rd_next;
        end
    end

    assign alu_instruction             = ctrl_q.alu;
    assign immediate_value             = imm_q;
    assign instruction_format_type     = ctrl_q.fmt;
    assign write_back_type             = ctrl_q.wb;
    assign read_status                 = ctrl_q.rsize;
    assign write_status                = ctrl_q.wsize;
    assign load_signed                 = ctrl_q.lsigned;
    assign destination_register_number = rd_q;
    assign pc_for_input_a              = ctrl_q.pc_a;
    assign change_branch_instruction   = ctrl_q.branch;

endmodule

// File: tb/tb_rv32i_instruction_decoder.sv
// Directed self-checking bench for rv32i_instruction_decoder.
// Expected values are hand-decoded from each instruction encoding.
module tb_rv32i_instruction_decoder;

    logic        clk;
    logic        reset;
    logic [31:0] IR;
    logic [4:0]  alu_instruction;
    logic [31:0] immediate_value;
    logic [2:0]  instruction_format_type;
    logic [1:0]  write_back_type;
    logic [1:0]  read_status;
    logic [1:0]  write_status;
    logic        load_signed;
    logic [4:0]  destination_register_number;
    logic        pc_for_input_a;
    logic        change_branch_instruction;

    int checks   = 0;
    int failures = 0;

    rv32i_instruction_decoder #(.XLEN(32)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .IR                          (IR),
        .alu_instruction             (alu_instruction),
        .immediate_value             (immediate_value),
        .instruction_format_type     (instruction_format_type),
        .write_back_type             (write_back_type),
        .read_status                 (read_status),
        .write_status                (write_status),
        .load_signed                 (load_signed),
        .destination_register_number (destination_register_number),
        .pc_for_input_a              (pc_for_input_a),
        .change_branch_instruction   (change_branch_instruction)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive IR away from the edge, then sample one unit after the capturing edge.
    task automatic applyStimulus(input logic [31:0] ir);
        @(negedge clk);
        IR = ir;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name,
                               input logic [2:0] fmt, input logic [4:0] alu,
                               input logic [31:0] imm, input logic [1:0] wb,
                               input logic [1:0] rs, input logic [1:0] ws,
                               input logic ls, input logic [4:0] rd,
                               input logic pca, input logic br);
        chk({name, ".fmt"}, {29'd0, instruction_format_type}, {29'd0, fmt});
        chk({name, ".alu"}, {27'd0, alu_instruction}, {27'd0, alu});
        chk({name, ".imm"}, immediate_value, imm);
        chk({name, ".wb"},  {30'd0, write_back_type}, {30'd0, wb});
        chk({name, ".rd_size"}, {30'd0, read_status}, {30'd0, rs});
        chk({name, ".wr_size"}, {30'd0, write_status}, {30'd0, ws});
        chk({name, ".lsigned"}, {31'd0, load_signed}, {31'd0, ls});
        chk({name, ".rd"},  {27'd0, destination_register_number}, {27'd0, rd});
        chk({name, ".pc_a"}, {31'd0, pc_for_input_a}, {31'd0, pca});
        chk({name, ".branch"}, {31'd0, change_branch_instruction}, {31'd0, br});
    endtask

    initial begin
        $display("[TB] rv32i_instruction_decoder directed test");
        reset = 1'b0;
        IR    = 32'h002081B3;
        #2;
        checkOutput("reset", 3'd0, 5'd0, 32'h0, 2'd0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        //                      name        fmt   alu     imm            wb    rs    ws    ls    rd     pca   br
        applyStimulus(32'h002081B3);
        checkOutput("add",      3'd1, 5'd0,  32'h00000000, 2'd1, 2'd0, 2'd0, 1'b0, 5'd3,  1'b0, 1'b0);
        applyStimulus(32'h402081B3);
        checkOutput("sub",      3'd1, 5'd1,  32'h00000000, 2'd1, 2'd0, 2'd0, 1'b0, 5'd3,  1'b0, 1'b0);
        applyStimulus(32'hFFC12283);
        checkOutput("lw",       3'd2, 5'd0,  32'hFFFFFFFC, 2'd2, 2'd3, 2'd0, 1'b1, 5'd5,  1'b0, 1'b0);
        applyStimulus(32'h0024D403);
        checkOutput("lhu",      3'd2, 5'd0,  32'h00000002, 2'd2, 2'd2, 2'd0, 1'b0, 5'd8,  1'b0, 1'b0);
        applyStimulus(32'h4032D213);
        checkOutput("srai",     3'd2, 5'd7,  32'h00000403, 2'd1, 2'd0, 2'd0, 1'b0, 5'd4,  1'b0, 1'b0);
        applyStimulus(32'hFFF5B513);
        checkOutput("sltiu",    3'd2, 5'd4,  32'hFFFFFFFF, 2'd1, 2'd0, 2'd0, 1'b0, 5'd10, 1'b0, 1'b0);
        applyStimulus(32'h00608423);
        checkOutput("sb",       3'd3, 5'd0,  32'h00000008, 2'd0, 2'd0, 2'd1, 1'b0, 5'd0,  1'b0, 1'b0);
        applyStimulus(32'hFE609F23);
        checkOutput("sh",       3'd3, 5'd0,  32'hFFFFFFFE, 2'd0, 2'd0, 2'd2, 1'b0, 5'd0,  1'b0, 1'b0);
        applyStimulus(32'hFE208CE3);
        checkOutput("beq",      3'd4, 5'd10, 32'hFFFFFFF8, 2'd0, 2'd0, 2'd0, 1'b0, 5'd0,  1'b0, 1'b1);
        applyStimulus(32'h0020F263);
        checkOutput("bgeu",     3'd4, 5'd15, 32'h00000004, 2'd0, 2'd0, 2'd0, 1'b0, 5'd0,  1'b0, 1'b1);
        applyStimulus(32'h0020A263);
        checkOutput("br_f3_010", 3'd0, 5'd0, 32'h00000000, 2'd0, 2'd0, 2'd0, 1'b0, 5'd0,  1'b0, 1'b0);
        applyStimulus(32'h010000EF);
        checkOutput("jal",      3'd6, 5'd0,  32'h00000010, 2'd3, 2'd0, 2'd0, 1'b0, 5'd1,  1'b1, 1'b1);
        applyStimulus(32'h000280E7);
        checkOutput("jalr",     3'd2, 5'd0,  32'h00000000, 2'd3, 2'd0, 2'd0, 1'b0, 5'd1,  1'b0, 1'b1);
        applyStimulus(32'hFFFFF117);
        checkOutput("auipc",    3'd5, 5'd0,  32'hFFFFF000, 2'd1, 2'd0, 2'd0, 1'b0, 5'd2,  1'b1, 1'b0);
        applyStimulus(32'hFFFFFFFF);
        checkOutput("all_ones", 3'd0, 5'd0,  32'h00000000, 2'd0, 2'd0, 2'd0, 1'b0, 5'd0,  1'b0, 1'b0);
        applyStimulus(32'h0000000F);
        checkOutput("fence",    3'd0, 5'd0,  32'h00000000, 2'd0, 2'd0, 2'd0, 1'b0, 5'd0,  1'b0, 1'b0);
`ifdef RV32M_EN
        applyStimulus(32'h023100B3);
        checkOutput("mul",      3'd1, 5'd17, 32'h00000000, 2'd1, 2'd0, 2'd0, 1'b0, 5'd1,  1'b0, 1'b0);
        applyStimulus(32'h023150B3);
        checkOutput("divu",     3'd1, 5'd22, 32'h00000000, 2'd1, 2'd0, 2'd0, 1'b0, 5'd1,  1'b0, 1'b0);
`else
        applyStimulus(32'h023100B3);
        checkOutput("mul_off",  3'd0, 5'd0,  32'h00000000, 2'd0, 2'd0, 2'd0, 1'b0, 5'd0,  1'b0, 1'b0);
        applyStimulus(32'h023150B3);
        checkOutput("divu_off", 3'd0, 5'd0,  32'h00000000, 2'd0, 2'd0, 2'd0, 1'b0, 5'd0,  1'b0, 1'b0);
`endif
        applyStimulus(32'h123453B7);
        checkOutput("lui",      3'd5, 5'd16, 32'h12345000, 2'd1, 2'd0, 2'd0, 1'b0, 5'd7,  1'b0, 1'b0);

        // Mid-cycle reset: outputs must clear before the next clock edge.
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_rst", 3'd0, 5'd0, 32'h00000000, 2'd0, 2'd0, 2'd0, 1'b0, 5'd0,  1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(32'h002081B3);
        checkOutput("add_again", 3'd1, 5'd0, 32'h00000000, 2'd1, 2'd0, 2'd0, 1'b0, 5'd3,  1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
